// File: rtl/alu_txn_master.sv
// Transaction initiator for the 3-phase 4-bit ALU: issues operands on the IDLE
// phase, captures the ALU outputs one frame later, checks them and queues tagged responses.
module alu_txn_master #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [1:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic [2:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             mismatch_sticky,
  output logic [1:0]       phase
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_FW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_EXEC = 2'd1,
    PH_WB   = 2'd2,
    PH_BAD  = 2'd3
  } phase_e;

  typedef struct packed {
    logic [3:0]       result;
    logic [2:0]       flags;
    logic [TAG_W-1:0] tag;
    logic             mismatch;
  } rsp_t;

  // Reference behaviour of the ALU: {result, carry, zero, overflow}.
  function automatic logic [6:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [4:0] w;
    logic       v;
    w = '0;
    v = 1'b0;
    case (op)
      2'b00: begin
        w = {1'b0, a} + {1'b0, b};
        v = (a[3] == b[3]) && (a[3] != w[3]);
      end
      2'b01: begin
        w = {1'b0, a} - {1'b0, b};
        v = (a[3] != b[3]) && (a[3] != w[3]);
      end
      2'b10:   w = {1'b0, a & b};
      default: w = {1'b0, a | b};
    endcase
    return {w[3:0], w[4], (w[3:0] == 4'd0), v};
  endfunction

  // ---------------------------------------------------------------------------
  // Phase tracker, locked to the ALU frame by the shared reset release
  // ---------------------------------------------------------------------------
  phase_e phase_q, phase_d;
  logic   in_idle;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= PH_IDLE;
    else        phase_q <= phase_d;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    phase_d = PH_IDLE;
    case (phase_q)
      PH_IDLE: phase_d = PH_EXEC;
      PH_EXEC: phase_d = PH_WB;
      default: phase_d = PH_IDLE;
    endcase
  end

  always_comb begin
    in_idle = (phase_q == PH_IDLE);
    phase   = phase_q;
  end

  // ---------------------------------------------------------------------------
  // Request side: operand registers, tag and golden expectation
  // ---------------------------------------------------------------------------
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [6:0]       exp_q, exp_d;
  logic             inflight_q, inflight_d;

  logic [CNT_FW-1:0] count_q, count_d;
  logic [CNT_FW:0]   occupancy;
  logic              accept, capture, push, pop;

  // The in-flight slot is reserved so its capture always finds room.
  always_comb begin
    occupancy = {1'b0, count_q} + {{CNT_FW{1'b0}}, inflight_q};
    req_ready = rst_n && in_idle && (occupancy < (CNT_FW + 1)'(DEPTH));
    accept    = req_valid && req_ready;
    capture   = in_idle && inflight_q;
  end

  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tag_d      = tag_q;
    exp_d      = exp_q;
    inflight_d = inflight_q;
    if (capture) inflight_d = 1'b0;
    if (accept) begin
      alu_a_d    = req_a;
      alu_b_d    = req_b;
      alu_op_d   = req_op;
      tag_d      = req_tag;
      exp_d      = golden(req_a, req_b, req_op);
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tag_q      <= '0;
      exp_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tag_q      <= tag_d;
      exp_q      <= exp_d;
      inflight_q <= inflight_d;
    end
  end

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;

  // ---------------------------------------------------------------------------
  // Capture and comparison
  // ---------------------------------------------------------------------------
  logic [6:0]       observed;
  logic             cap_mismatch;
  rsp_t             cap_entry;
  logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
  logic             sticky_q, sticky_d;

  always_comb begin
    observed     = {alu_result, alu_carry, alu_zero, alu_overflow};
    cap_mismatch = (observed != exp_q);
    cap_entry    = '{result:   alu_result,
                     flags:    {alu_carry, alu_zero, alu_overflow},
                     tag:      tag_q,
                     mismatch: cap_mismatch};
  end

  always_comb begin
    mm_cnt_d = mm_cnt_q;
    sticky_d = sticky_q;
    if (capture && cap_mismatch) begin
      sticky_d = 1'b1;
      if (mm_cnt_q != '1) mm_cnt_d = mm_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_cnt_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      mm_cnt_q <= mm_cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign mismatch_cnt    = mm_cnt_q;
  assign mismatch_sticky = sticky_q;

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  rsp_t             mem_q [DEPTH];
  rsp_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    rsp_valid = (count_q != '0);
    push      = capture;
    pop       = rsp_valid && rsp_ready;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an empty FIFO masks its outputs
  // to zero, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cap_entry;
  end

  always_comb begin
    head         = rsp_valid ? mem_q[rd_ptr_q] : '0;
    rsp_result   = head.result;
    rsp_flags    = head.flags;
    rsp_tag      = head.tag;
    rsp_mismatch = head.mismatch;
  end

endmodule

// File: doc/alu_txn_master.md
Name: alu_txn_master

Overview:
- Transaction-level initiator for the 3-phase 4-bit ALU (IDLE→EXEC→WB, writeback on WB).
- Accepts operand requests on a valid/ready port and drives the ALU operand inputs aligned to the ALU frame.
- Captures the ALU result and flags, checks them against an internal golden model, and returns tagged responses through a response FIFO.
- Sits between the test/stimulus fabric and the ALU; both blocks share clk and rst_n so their phases stay locked.

Parameters:
- DEPTH, 4, response FIFO entries (power of 2, ≥2).
- TAG_W, 4, request/response tag width.
- CNT_W, 8, mismatch counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when both valid and ready are high
- req_a  in  4  operand A
- req_b  in  4  operand B
- req_op  in  2  00 add, 01 sub, 10 and, 11 or
- req_tag  in  TAG_W  returned with the response
- alu_a  out  4  registered operand A to the ALU
- alu_b  out  4  registered operand B to the ALU
- alu_op  out  2  registered op to the ALU
- alu_result  in  4  ALU result
- alu_carry  in  1  ALU carry flag
- alu_zero  in  1  ALU zero flag
- alu_overflow  in  1  ALU overflow flag
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer pops the head when high with rsp_valid
- rsp_result  out  4  captured result
- rsp_flags  out  3  {carry, zero, overflow}
- rsp_tag  out  TAG_W  tag of the response
- rsp_mismatch  out  1  captured value differed from the golden model
- mismatch_cnt  out  CNT_W  saturating count of mismatches
- mismatch_sticky  out  1  set on first mismatch, cleared only by reset
- phase  out  2  mirror phase: 0=IDLE, 1=EXEC, 2=WB

Behaviour:
- Reset (asynchronous, rst_n=0):
  - phase=0.
  - alu_a, alu_b, alu_op = 0.
  - FIFO empty, so rsp_valid=0; rsp_result, rsp_flags, rsp_tag, rsp_mismatch = 0.
  - mismatch_cnt=0, mismatch_sticky=0.
  - In-flight flag cleared; req_ready=0 while reset is asserted.
  - Reset mid-transaction drops the in-flight request with no response.
- Phase counter: 0→1→2→0 every cycle, free-running, never stalls. Value 3 is illegal and recovers to 0.
- req_ready = (phase==0) && (fifo_count + inflight < DEPTH). Combinational; does not depend on req_valid.
- Accept (phase 0 handshake):
  - On the edge ending the phase-0 cycle t, load alu_a/alu_b/alu_op, the tag, and the golden expectation; set inflight.
  - Operands hold through phases 1 and 2 and are never changed outside a phase-0 accept.
  - With no accept, the operands hold their previous value.
- Capture:
  - In cycle t+3 (next phase 0) with inflight=1, sample the alu_* inputs.
  - On the edge ending t+3, push {result, flags, tag, mismatch} into the FIFO and clear inflight. A new accept on the same edge sets inflight again.
  - rsp_valid rises in cycle t+4 when the FIFO was empty, so throughput is one transaction per 3 cycles.
- Golden model (5-bit arithmetic):
  - add = A+B; carry = bit4; ovf = (A3==B3) && (A3!=sum3).
  - sub = A−B; carry = bit4 (borrow); ovf = (A3!=B3) && (A3!=diff3).
  - and/or: carry=0, ovf=0.
  - zero = (result[3:0]==0) for all ops.
- Mismatch:
  - rsp_mismatch is set when any of result, carry, zero or overflow differs from the golden model.
  - Each mismatch increments mismatch_cnt, saturating at all-ones, and sets mismatch_sticky.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged. This is legal when full only because inflight is reserved in the req_ready term.
  - Pop when empty is ignored.
  - Output data is stable while rsp_valid=1 and rsp_ready=0.
  - Pointers wrap modulo DEPTH.
- Alignment: phase lock is guaranteed only when the ALU and this block share the same reset deassertion edge. No resynchronisation is performed.

Test Plan:
- Reset release, ADD A=7 B=9 tag=1, rsp_ready=1 → accepted in the first phase-0 cycle; rsp_valid 4 cycles later with result=0, flags=3'b110, tag=1, mismatch=0.
- SUB A=8 B=1 → result=7, flags=3'b001 (overflow), carry=0.
- AND A=0xC B=0x3, then OR A=0 B=0 issued back-to-back every 3 cycles → both responses zero=1, in order, with tags preserved.
- rsp_ready=0, issue 6 requests → req_ready drops after 4 are accepted or in flight; FIFO holds 4; raise rsp_ready → 4 responses in order, then requests resume.
- Bench forces alu_result=5 for an ADD 2+2 → rsp_mismatch=1, mismatch_cnt=1, sticky=1; a following correct transaction gives mismatch=0 and the count stays 1.
- Assert rst_n in phase 1 with a request in flight and 2 FIFO entries → all outputs return to reset values, no response emerges, and phase restarts at 0.
